// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin FIFO write-port arbiter.
package fifo_rr_arbiter_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  localparam int unsigned CntWidth = 8;

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Rotate-priority encoder: first set request bit scanning start+1, start+2, ... with start last.
module fifo_rr_arbiter_rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] start_i,
  output logic [IdxW-1:0] idx_o,
  output logic            found_o
);

  logic [IdxW-1:0] cand [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      cand[i] = IdxW'(({{(32 - IdxW){1'b0}}, start_i} + 32'(i) + 32'd1) % N);
    end
  end

  // Walk from the lowest-priority candidate upwards so the earliest hit wins.
  always_comb begin
    idx_o   = start_i;
    found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[cand[i]]) begin
        idx_o   = cand[i];
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ requesters,
// with a per-tenure write quantum and zero-latency write path.
module fifo_rr_arbiter
  import fifo_rr_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned QUANTUM = 4,
  localparam int unsigned IdxW   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  input  logic                   fifo_full,
  output logic                   fifo_wr_en,
  output logic [WIDTH-1:0]       fifo_din,
  output logic [IdxW-1:0]        grant_id,
  output logic                   busy
);

  state_e              state_q, state_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  logic [IdxW-1:0] pick_idx;
  logic            pick_found;
  logic            hold;
  logic [IdxW-1:0] grant_idx;
  logic            grant_vld;
  logic            transfer;
  logic            new_tenure;

  fifo_rr_arbiter_rr_pick #(
    .N    (N_REQ),
    .IdxW (IdxW)
  ) u_rr_pick (
    .req_i   (req_valid),
    .start_i (owner_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign hold       = (state_q == StBusy) && req_valid[owner_q] &&
                      (cnt_q < CntWidth'(QUANTUM));
  assign grant_idx  = hold ? owner_q : pick_idx;
  assign grant_vld  = hold || pick_found;
  assign transfer   = grant_vld && !fifo_full && !rst;
  assign new_tenure = (state_q == StIdle) || (grant_idx != owner_q) ||
                      (cnt_q == CntWidth'(QUANTUM));

  assign fifo_wr_en = transfer;
  assign grant_id   = owner_q;
  assign busy       = (state_q == StBusy);

  always_comb begin
    req_ready = '0;
    fifo_din  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (transfer && (grant_idx == IdxW'(i))) begin
        req_ready[i] = 1'b1;
        fifo_din     = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Backpressure freezes everything so a stalled owner keeps its tenure.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (transfer) begin
      state_d = StBusy;
      owner_d = grant_idx;
      cnt_d   = new_tenure ? CntWidth'(1) : cnt_q + CntWidth'(1);
    end else if (!fifo_full) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= IdxW'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/fifo_rr_arbiter.md
FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one FIFO write port (2..16).
REQ-002 Parameter WIDTH, default 8: data width, equal to the downstream FIFO WIDTH.
REQ-003 Parameter QUANTUM, default 4: maximum consecutive writes per tenure (1..255).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  N_REQ  per-requester word-available flag.
REQ-007 req_data  input  N_REQ*WIDTH  packed words; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 req_ready  output  N_REQ  one-hot write-accept strobe to the requesters.
REQ-009 fifo_full  input  1  full flag from the FIFO.
REQ-010 fifo_wr_en  output  1  FIFO write enable.
REQ-011 fifo_din  output  WIDTH  FIFO write data.
REQ-012 grant_id  output  clog2(N_REQ)  index of the current or most recent owner.
REQ-013 busy  output  1  high while state is BUSY.

Function
REQ-014 State is held in registers: state (IDLE/BUSY), owner (grant_id), cnt (8 bits); grant is combinational from these registers plus req_valid.
REQ-015 Hold rule: in BUSY, with req_valid[owner]=1 and cnt<QUANTUM, grant=owner.
REQ-016 Otherwise grant is the first asserted req_valid scanning owner+1, owner+2, ... mod N_REQ, with owner examined last.
REQ-017 No req_valid asserted: no grant.
REQ-018 transfer = grant exists AND fifo_full=0; fifo_wr_en=transfer, with zero latency (same cycle).
REQ-019 fifo_din = req_data of the granted requester when transfer=1, else all zeros.
REQ-020 req_ready[i]=1 only when transfer=1 and grant=i; at most one bit high.
REQ-021 On transfer: owner<=grant and state<=BUSY.
REQ-022 On transfer, cnt<=1 for a new tenure (state was IDLE, grant!=owner, or cnt==QUANTUM); otherwise cnt<=cnt+1.
REQ-023 fifo_full=1: no transfer; state, owner and cnt hold, so backpressure never forfeits a tenure.
REQ-024 In BUSY with fifo_full=0 and req_valid[owner]=0 and no transfer: state<=IDLE, owner held as the round-robin pointer.
REQ-025 Quantum expiry with only the owner requesting: scan wraps to owner, owner is re-granted, cnt<=1.
REQ-026 A requester dropping req_valid mid-tenure loses ownership that cycle; the scan starts at owner+1.
REQ-027 Words are never duplicated or dropped: each req_ready pulse corresponds to exactly one fifo_wr_en.

Reset
REQ-028 rst=1 forces state=IDLE, owner=N_REQ-1 (first scan starts at 0), cnt=0 at the next clock edge.
REQ-029 While rst=1, fifo_wr_en=0, req_ready=0 and fifo_din=0 combinationally, regardless of inputs.
REQ-030 rst asserted mid-tenure discards the tenure; the first grant after release follows REQ-016 from index 0.

Structure
REQ-031 A shared package holds the IDLE/BUSY state encoding and the cnt width constant (8).
REQ-032 Sub-module rr_pick (combinational rotate-priority encoder: request vector and start index in, index and found flag out) is the natural split; everything else stays flat.

Verification
REQ-033 Reset: rst held 2 cycles, all req_valid=1 -> fifo_wr_en=0, req_ready=0; first grant after release is grant_id=0.
REQ-034 Quantum: N_REQ=4, QUANTUM=4, all valid, fifo_full=0 -> grants 0,0,0,0,1,1,1,1,2,... and 16 writes in 16 cycles.
REQ-035 Backpressure: requester 1 is owner with cnt=2 and fifo_full=1 for 5 cycles -> no writes, grant_id=1, cnt=2 held; after release, 2 more writes from requester 1, then requester 2.
REQ-036 Drop: owner 2 deasserts valid after 1 write while 0 and 3 are valid -> next grant 3, then 0; busy stays high.
REQ-037 Sole requester: only requester 3 valid for 10 cycles -> 10 consecutive writes, cnt sequence 1,2,3,4,1,2,3,4,1,2.
REQ-038 Data integrity: requester i sends i*16+k for k=0..7, with random fifo_full -> scoreboard shows per-requester order preserved and no loss or duplication.
